// File: rtl/regfile_pkg.sv
// Shared definitions for the write-back register file: the write-back
// source encoding used by the controller and the register file.
package regfile_pkg;

  typedef logic [1:0] vsel_t;

  localparam vsel_t VSEL_MDATA = 2'b00;
  localparam vsel_t VSEL_IMM   = 2'b01;
  localparam vsel_t VSEL_PC    = 2'b10;
  localparam vsel_t VSEL_C     = 2'b11;

endpackage

// File: rtl/regfile_wb_rf_cell.sv
// Single register-file entry: DATA_W load-enabled register with
// asynchronous active-low clear.
module rf_cell #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q, q_d;

  // load new data when enabled, otherwise hold
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // storage with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_wb.sv
// Register file with write-back source mux, two combinational read ports
// and a pending-load scoreboard. Optional same-cycle write-to-read bypass
// is enabled by defining RF_BYPASS_EN.
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [1:0]        vsel,
  input  logic [AW-1:0]     writenum,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] mdata,
  input  logic [DATA_W-1:0] sximm8,
  input  logic [PC_W-1:0]   PC,
  input  logic [AW-1:0]     readnum_a,
  input  logic [AW-1:0]     readnum_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              mark_busy,
  input  logic [AW-1:0]     mark_num,
  output logic [NREGS-1:0]  busy_vec,
  output logic              stall_a,
  output logic              stall_b,
  output logic              waw_err,
  output logic [DATA_W-1:0] datapath_out
);

  logic [DATA_W-1:0]             wb_data;
  logic [NREGS-1:0][DATA_W-1:0]  regs;
  logic [NREGS-1:0]              busy_q, busy_d;
  logic                          waw_q, waw_d;
  logic                          wr_busy;

  // write-back source select; every encoding decoded
  always_comb begin
    wb_data = C;
    case (vsel_t'(vsel))
      VSEL_MDATA: wb_data = mdata;
      VSEL_IMM:   wb_data = sximm8;
      VSEL_PC:    wb_data = DATA_W'(PC);
      default:    wb_data = C;
    endcase
  end

  // one cell per register; an out-of-range writenum matches no cell
  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    localparam logic [AW-1:0] IDX = AW'(i);
    rf_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (write && (writenum == IDX)),
      .d     (wb_data),
      .q     (regs[i])
    );
  end

  // scoreboard next state: a new mark beats a retiring load on the same index
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (mark_busy && (mark_num == AW'(i)))
        busy_d[i] = 1'b1;
      else if (write && (vsel == VSEL_MDATA) && (writenum == AW'(i)))
        busy_d[i] = 1'b0;
    end
  end

  // sticky write-after-write error: non-memory write onto a pending register
  always_comb begin
    wr_busy = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (writenum == AW'(i)) wr_busy = busy_q[i];
    waw_d = waw_q | (write && (vsel != VSEL_MDATA) && wr_busy);
  end

  // scoreboard and error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      waw_q  <= waw_d;
    end
  end

  // read ports; out-of-range index matches nothing and reads 0 / no stall
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (readnum_a == AW'(i)) begin
        rdata_a = regs[i];
        stall_a = busy_q[i];
`ifdef RF_BYPASS_EN
        if (write && (writenum == AW'(i))) begin
          rdata_a = wb_data;
          if ((vsel == VSEL_MDATA) && !(mark_busy && (mark_num == AW'(i))))
            stall_a = 1'b0;
        end
`endif
      end
      if (readnum_b == AW'(i)) begin
        rdata_b = regs[i];
        stall_b = busy_q[i];
`ifdef RF_BYPASS_EN
        if (write && (writenum == AW'(i))) begin
          rdata_b = wb_data;
          if ((vsel == VSEL_MDATA) && !(mark_busy && (mark_num == AW'(i))))
            stall_b = 1'b0;
        end
`endif
      end
    end
  end

  assign busy_vec     = busy_q;
  assign waw_err      = waw_q;
  assign datapath_out = C;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: an 8-entry instance plus a 6-entry
// instance sharing the same stimulus to exercise out-of-range indices.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        write = 1'b0;
  logic [1:0]  vsel = 2'b00;
  logic [2:0]  writenum = '0;
  logic [15:0] C = '0, mdata = '0, sximm8 = '0;
  logic [7:0]  PC = '0;
  logic [2:0]  readnum_a = '0, readnum_b = '0;
  logic        mark_busy = 1'b0;
  logic [2:0]  mark_num = '0;

  logic [15:0] rdata_a, rdata_b, dp_out;
  logic [7:0]  busy_vec;
  logic        stall_a, stall_b, waw_err;

  logic [15:0] rdata_a6, rdata_b6, dp_out6;
  logic [5:0]  busy_vec6;
  logic        stall_a6, stall_b6, waw_err6;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp6 [6];

  always #5 clk = ~clk;

  regfile_wb #(.DATA_W(16), .NREGS(8), .AW(3), .PC_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .write(write), .vsel(vsel), .writenum(writenum),
    .C(C), .mdata(mdata), .sximm8(sximm8), .PC(PC),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mark_busy(mark_busy), .mark_num(mark_num), .busy_vec(busy_vec),
    .stall_a(stall_a), .stall_b(stall_b), .waw_err(waw_err),
    .datapath_out(dp_out)
  );

  regfile_wb #(.DATA_W(16), .NREGS(6), .AW(3), .PC_W(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .write(write), .vsel(vsel), .writenum(writenum),
    .C(C), .mdata(mdata), .sximm8(sximm8), .PC(PC),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .rdata_a(rdata_a6), .rdata_b(rdata_b6),
    .mark_busy(mark_busy), .mark_num(mark_num), .busy_vec(busy_vec6),
    .stall_a(stall_a6), .stall_b(stall_b6), .waw_err(waw_err6),
    .datapath_out(dp_out6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // async reset asserted mid-cycle
    #7 rst_n = 1'b0;
    #1;
    chk("rst_busy_now", 32'(busy_vec), 32'h0);
    chk("rst_waw_now", 32'(waw_err), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      readnum_a = 3'(i);
      readnum_b = 3'(i);
      #1;
      chk("rst_rd_a", 32'(rdata_a), 32'h0);
      chk("rst_rd_b", 32'(rdata_b), 32'h0);
    end
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_waw", 32'(waw_err), 32'h0);

    // PC source into r3
    write = 1'b1; vsel = 2'b10; writenum = 3'd3; PC = 8'hA5; readnum_a = 3'd3;
    #1;
`ifdef RF_BYPASS_EN
    chk("pc_bypass", 32'(rdata_a), 32'h00A5);
`else
    chk("pc_pre_edge", 32'(rdata_a), 32'h0000);
`endif
    tick();
    write = 1'b0;
    #1;
    chk("pc_r3", 32'(rdata_a), 32'h00A5);

    // immediate source into r5
    write = 1'b1; vsel = 2'b01; writenum = 3'd5; sximm8 = 16'hFFF0;
    tick();
    write = 1'b0; readnum_b = 3'd5;
    #1;
    chk("imm_r5", 32'(rdata_b), 32'hFFF0);

    // mark r2 pending
    mark_busy = 1'b1; mark_num = 3'd2;
    tick();
    mark_busy = 1'b0; readnum_a = 3'd2;
    #1;
    chk("mark_busy_vec", 32'(busy_vec), 32'h04);
    chk("mark_stall_a", 32'(stall_a), 32'h1);
    chk("mark_stall_b", 32'(stall_b), 32'h0);

    // load retires into r2
    write = 1'b1; vsel = 2'b00; writenum = 3'd2; mdata = 16'h1234;
    #1;
`ifdef RF_BYPASS_EN
    chk("ld_stall_bypass", 32'(stall_a), 32'h0);
    chk("ld_data_bypass", 32'(rdata_a), 32'h1234);
`else
    chk("ld_stall_pre", 32'(stall_a), 32'h1);
`endif
    tick();
    write = 1'b0;
    #1;
    chk("ld_busy_clr", 32'(busy_vec), 32'h00);
    chk("ld_r2", 32'(rdata_a), 32'h1234);
    chk("ld_stall_clr", 32'(stall_a), 32'h0);
    chk("ld_no_waw", 32'(waw_err), 32'h0);

    // mark r6, then retire and re-mark in the same cycle
    mark_busy = 1'b1; mark_num = 3'd6;
    tick();
    write = 1'b1; vsel = 2'b00; writenum = 3'd6; mdata = 16'h5555; readnum_a = 3'd6;
    #1;
    chk("remark_stall_pre", 32'(stall_a), 32'h1);
    tick();
    write = 1'b0; mark_busy = 1'b0;
    #1;
    chk("remark_r6", 32'(rdata_a), 32'h5555);
    chk("remark_busy", 32'(busy_vec), 32'h40);
    chk("remark_stall", 32'(stall_a), 32'h1);

    // non-memory write onto pending r1
    mark_busy = 1'b1; mark_num = 3'd1;
    tick();
    mark_busy = 1'b0;
    write = 1'b1; vsel = 2'b11; writenum = 3'd1; C = 16'h0BAD; readnum_b = 3'd1;
    #1;
    chk("dp_out", 32'(dp_out), 32'h0BAD);
    chk("waw_pre", 32'(waw_err), 32'h0);
    tick();
    write = 1'b0;
    #1;
    chk("waw_set", 32'(waw_err), 32'h1);
    chk("waw_busy_kept", 32'(busy_vec), 32'h42);
    chk("waw_r1", 32'(rdata_b), 32'h0BAD);
    tick();
    tick();
    chk("waw_sticky", 32'(waw_err), 32'h1);

    // out-of-range write on the 6-entry instance
    write = 1'b1; vsel = 2'b11; writenum = 3'd7; C = 16'h7777;
    tick();
    write = 1'b0; readnum_a = 3'd7; readnum_b = 3'd6;
    #1;
    chk("rng8_r7", 32'(rdata_a), 32'h7777);
    chk("rng6_rd7", 32'(rdata_a6), 32'h0);
    chk("rng6_rd6", 32'(rdata_b6), 32'h0);
    chk("rng6_stall6", 32'(stall_b6), 32'h0);
    chk("rng6_busy", 32'(busy_vec6), 32'h02);
    exp6[0] = 16'h0000; exp6[1] = 16'h0BAD; exp6[2] = 16'h1234;
    exp6[3] = 16'h00A5; exp6[4] = 16'h0000; exp6[5] = 16'hFFF0;
    for (int i = 0; i < 6; i++) begin
      readnum_a = 3'(i);
      #1;
      chk("rng6_keep", 32'(rdata_a6), 32'(exp6[i]));
    end

    // same-cycle write/read of r4
    write = 1'b1; vsel = 2'b11; writenum = 3'd4; C = 16'hBEEF; readnum_b = 3'd4;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_r4", 32'(rdata_b), 32'hBEEF);
`else
    chk("nobyp_r4", 32'(rdata_b), 32'h0000);
`endif
    tick();
    write = 1'b0;
    #1;
    chk("r4_after", 32'(rdata_b), 32'hBEEF);

    // reset mid-operation discards pending marks
    mark_busy = 1'b1; mark_num = 3'd3;
    tick();
    mark_busy = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(busy_vec), 32'h4A);
    #2 rst_n = 1'b0;
    #1;
    readnum_a = 3'd1;
    #1;
    chk("rst2_busy", 32'(busy_vec), 32'h0);
    chk("rst2_waw", 32'(waw_err), 32'h0);
    chk("rst2_r1", 32'(rdata_a), 32'h0);
    chk("rst2_busy6", 32'(busy_vec6), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Parametrised register file with integrated write-back source select, two combinational read ports and a pending-load scoreboard.
- Sits between the instruction decoder/FSM and the ALU datapath. It replaces the fixed 8-entry write stage with a generic block of NREGS entries, each DATA_W wide.
- The scoreboard tracks registers awaiting memory data, so the controller can stall dependent reads.

Parameters:
- DATA_W, 16: register and data-path width in bits.
- NREGS, 8: number of registers; 2..256.
- AW, 3: register index width; must satisfy 2**AW >= NREGS.
- PC_W, 8: program-counter width; must satisfy PC_W <= DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- write  in  1  write enable for the register file.
- vsel  in  2  write-back source: 00 mdata, 01 sximm8, 10 PC, 11 C.
- writenum  in  AW  destination register index.
- C  in  DATA_W  ALU result.
- mdata  in  DATA_W  memory read data.
- sximm8  in  DATA_W  sign-extended immediate.
- PC  in  PC_W  program counter.
- readnum_a  in  AW  read port A index.
- readnum_b  in  AW  read port B index.
- rdata_a  out  DATA_W  read port A data.
- rdata_b  out  DATA_W  read port B data.
- mark_busy  in  1  a load has been issued; mark mark_num as pending.
- mark_num  in  AW  destination index of the issued load.
- busy_vec  out  NREGS  scoreboard; bit i set means register i is pending.
- stall_a  out  1  register readnum_a is pending.
- stall_b  out  1  register readnum_b is pending.
- waw_err  out  1  sticky error: a non-memory write landed on a pending register.
- datapath_out  out  DATA_W  equals C, passed through combinationally.

Behaviour:
- Reset: asynchronous, active low.
  - All registers, busy_vec and waw_err clear to 0 immediately.
  - Reset mid-operation discards any pending load marks.
- Write data selection (combinational):
  - 00 selects mdata; 01 selects sximm8; 10 selects PC zero-extended to DATA_W; 11 selects C.
  - No latches; every vsel value is decoded.
- Register write:
  - When write=1, register[writenum] is updated at the rising clk edge.
  - writenum >= NREGS: the write is silently ignored; no register or scoreboard bit changes.
- Reads:
  - rdata_a/rdata_b are combinational from the register array.
  - An out-of-range read index returns 0 and gives stall 0.
- Scoreboard, per edge, for register i:
  - Set if mark_busy=1 and mark_num==i.
  - Else clear if write=1, vsel=00 and writenum==i.
  - Else hold.
  - Simultaneous set and clear on the same index: set wins, because a new load is issued while the old load retires. The data write still occurs.
- stall_x = busy_vec[readnum_x], taken from the registered busy state.
- waw_err:
  - Set at the edge where write=1, vsel!=00 and busy_vec[writenum]=1.
  - The write is still performed; the busy bit is unchanged.
  - Cleared only by reset.
- Latency: write to readback is 1 cycle (visible after the edge); mark to stall is 1 cycle.

Optional Feature:
- Macro: RF_BYPASS_EN.
- With the macro defined:
  - If write=1, writenum is in range and readnum_x==writenum, then rdata_x equals the selected write data in the same cycle.
  - If that write also has vsel=00, stall_x is forced to 0 that cycle, unless mark_busy re-marks the same index in that cycle.
- Without the macro: reads see only the registered contents, and stall follows busy_vec exactly.

Decomposition:
- Package regfile_pkg holds:
  - VSEL_MDATA=2'b00, VSEL_IMM=2'b01, VSEL_PC=2'b10, VSEL_C=2'b11.
  - A vsel_t typedef.
- Sub-module rf_cell: a DATA_W load-enabled register with asynchronous active-low clear. It is instantiated NREGS times via generate.
- The scoreboard and write-back mux stay in the top level.

Test Plan:
- Reset then all reads: assert rst_n=0 mid-cycle, release; read all 8 -> all 0, busy_vec=0, waw_err=0.
- Source mux:
  - write=1, writenum=3, vsel=10, PC=8'hA5 -> rdata_a(readnum_a=3)=16'h00A5 next cycle.
  - vsel=01, sximm8=16'hFFF0 into r5 -> r5=16'hFFF0.
- Load scoreboard: mark_busy, mark_num=2 -> busy_vec=8'h04, stall_a=1 for readnum_a=2. Then write=1, vsel=00, mdata=16'h1234 to r2 -> busy cleared, rdata=16'h1234, stall_a=0.
- Simultaneous mark and retire on r6 -> r6 holds mdata and busy_vec[6] stays 1. Separately, vsel=11 write to busy r1 -> waw_err=1 and stays 1 until reset.
- Range check: NREGS=6, AW=3, write to writenum=7 -> no register changes; readnum_a=7 -> rdata_a=0.
- RF_BYPASS_EN defined: write r4 with C=16'hBEEF and readnum_b=4 in the same cycle -> rdata_b=16'hBEEF combinationally. Without the macro -> old r4 value until the edge.
